fdiv_seq: RTL and testbench
===========================

// Module: fdiv_seq
// PURPOSE
//  Iterative IEEE-754 single-precision divider, the inverse companion of the fmul multiplier.
//  Computes c_o = a_i / b_i, one quotient bit per clock (restoring division).
//  Valid/ready handshake on input and result; sits beside fmul in the FP datapath.
//  Denormal inputs and outputs are flushed to signed zero; rounding is round-to-nearest-even.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; only 32 is supported (elaboration error otherwise)
//  QBITS       26  localparam: quotient bits iterated (1 integer + 23 frac + guard + round)
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_i          in   1   reset; asynchronous, active-high
//  in_valid_i     in   1   operands a_i/b_i valid
//  in_ready_o     out  1   divider idle, can accept operands
//  a_i            in   32  dividend, IEEE-754 single
//  b_i            in   32  divisor, IEEE-754 single
//  res_valid_o    out  1   c_o holds a result
//  res_ready_i    in   1   consumer takes result
//  c_o            out  32  quotient, IEEE-754 single
//  flags_o        out  4   {invalid, div_by_zero, overflow, underflow}; only with FDIV_FLAGS_EN
// BEHAVIOUR
//  Reset: state=IDLE, in_ready_o=1, res_valid_o=0, c_o=0, flags_o=0; reset mid-op aborts the op, no result.
//  FSM IDLE -> DIV -> NORM -> DONE -> IDLE.
//   IDLE: in_ready_o=1. On in_valid_i&in_ready_o, latch sign=a^b, exp=ea-eb+127 (10b signed),
//     ma={1,fa}, mb={1,fb}, rem=ma. Special operands go straight to DONE; otherwise go to DIV with cnt=0.
//   DIV: in_ready_o=0. Each cycle: if rem>=mb then q bit=1, rem-=mb; rem<<=1; cnt++.
//     Leave after QBITS cycles.
//   NORM: if q[25]==0 then shift q left 1 and exp-=1. guard/round from q LSBs, sticky=|rem.
//     RNE increment; a mantissa carry-out increments exp.
//     exp>=255 -> +/-inf (overflow); exp<=0 -> signed zero (underflow).
//   DONE: res_valid_o=1, c_o stable until res_ready_i; on res_ready_i go to IDLE.
//     No new operand is accepted in the same cycle.
//  Latency: accept edge to res_valid_o = QBITS+2 cycles normal; 1 cycle for specials.
//  Throughput: one op at a time. in_valid_i while busy is ignored; producer must hold it.
//  Specials (sign = a^b unless NaN):
//   - NaN in, 0/0, or inf/inf -> 0x7FC00000 (invalid).
//   - x/0 (x finite nonzero) -> inf (div_by_zero).
//   - inf/finite -> inf.  finite/inf -> 0.  0/nonzero -> 0.  Denormal operand = 0.
// CONFIGURATION
//  FDIV_FLAGS_EN defined: flags_o port exists; flags are registered with c_o, valid with res_valid_o,
//   and cleared on reset and on accept.
//  FDIV_FLAGS_EN undefined: no flags_o port and no flag logic; c_o is identical in both builds.
// STRUCTURE
//  fp_pkg: EXP_W=8, MAN_W=23, BIAS=127, QNAN=32'h7FC00000, POS_INF=32'h7F800000,
//   FSM state encoding, fp class enum {ZERO,NORM,INF,NAN}.
//  Sub-module fp_classify (combinational): operand -> class, sign, exp, {1,frac}.
//   Instanced twice; fmul reuses it.
//  Datapath (remainder/quotient/exponent registers) and FSM stay in fdiv_seq.
// TESTING
//  1. 0x40C00000 / 0x40000000 (6/2) -> c_o=0x40400000, valid exactly 28 cycles after accept.
//  2. 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (RNE rounds up); 0xBF800000 / 0x40000000 -> 0xBF000000.
//  3. 0x3F800000 / 0x00000000 -> 0x7F800000, flags=0100, 1-cycle latency;
//     0/0 -> 0x7FC00000, flags=1000.
//  4. 0x7F7FFFFF / 0x3E800000 -> 0x7F800000 (overflow);
//     0x00800000 / 0x40000000 -> 0x00000000 (underflow).
//  5. res_ready_i low 5 cycles in DONE -> c_o/res_valid_o stable, in_ready_o=0; a second in_valid_i is ignored.
//  6. rst_i pulsed at DIV cycle 10 -> res_valid_o=0, in_ready_o=1 immediately; next op (1.5/0.5) -> 0x40400000.

Source files
------------

// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared IEEE-754 single-precision definitions for the FP datapath (fdiv_seq,
// fmul). Holds the field widths, bias, canonical special encodings, the
// divider FSM state encoding, the operand class enum and a small pack helper.
// -----------------------------------------------------------------------------
package fp_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int BIAS  = 127;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   // Divider control states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_NORM = 2'd2,
      S_DONE = 2'd3
   } fdiv_state_e;

   // Operand classes; denormals are reported as FP_ZERO (flush-to-zero)
   typedef enum logic [1:0] {
      FP_ZERO = 2'd0,
      FP_NORM = 2'd1,
      FP_INF  = 2'd2,
      FP_NAN  = 2'd3
   } fp_class_e;

   // Assemble a single-precision word from its fields
   function automatic logic [31:0] fp_pack(input logic             s,
                                           input logic [EXP_W-1:0] e,
                                           input logic [MAN_W-1:0] f);
      return {s, e, f};
   endfunction

endpackage

// File: rtl/fp_classify.sv
// -----------------------------------------------------------------------------
// fp_classify
// Combinational IEEE-754 single-precision operand decoder, shared by fdiv_seq
// and fmul. Denormal encodings (exp==0) are classed as zero.
// Ports:
//   op_i    in   32  operand
//   cls_o   out  2   class (FP_ZERO/FP_NORM/FP_INF/FP_NAN)
//   sign_o  out  1   sign bit
//   exp_o   out  8   biased exponent field
//   man_o   out  24  significand with hidden one, {1, frac}
// -----------------------------------------------------------------------------
module fp_classify
   import fp_pkg::*;
(
   input  logic [31:0]      op_i,
   output fp_class_e        cls_o,
   output logic             sign_o,
   output logic [EXP_W-1:0] exp_o,
   output logic [MAN_W:0]   man_o
);

   logic [MAN_W-1:0] frac;

   assign sign_o = op_i[31];
   assign exp_o  = op_i[30:23];
   assign frac   = op_i[22:0];
   assign man_o  = {1'b1, frac};

   always_comb begin
      cls_o = FP_NORM;
      if (exp_o == '0) begin
         cls_o = FP_ZERO;
      end else if (exp_o == '1) begin
         cls_o = (frac == '0) ? FP_INF : FP_NAN;
      end
   end

endmodule

// File: rtl/fdiv_seq.sv
// -----------------------------------------------------------------------------
// fdiv_seq
// Iterative IEEE-754 single-precision divider, c_o = a_i / b_i. Restoring
// division producing one quotient bit per clock, then a single normalise /
// round-to-nearest-even cycle. Denormals flush to signed zero. Special
// operands bypass the iteration and produce a result one cycle after accept.
//
// Optional feature macro: FDIV_FLAGS_EN adds the flags_o port and its logic.
//
// Ports:
//   clk_i        in   1   clock, rising edge
//   rst_i        in   1   asynchronous active-high reset
//   in_valid_i   in   1   operands valid
//   in_ready_o   out  1   idle, operands accepted
//   a_i          in   32  dividend
//   b_i          in   32  divisor
//   res_valid_o  out  1   c_o holds a result
//   res_ready_i  in   1   consumer takes the result
//   c_o          out  32  quotient
//   flags_o      out  4   {invalid, div_by_zero, overflow, underflow}
//                         (FDIV_FLAGS_EN only)
// -----------------------------------------------------------------------------
module fdiv_seq
   import fp_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic                  res_valid_o,
   input  logic                  res_ready_i,
   output logic [DATA_WIDTH-1:0] c_o
`ifdef FDIV_FLAGS_EN
   ,
   output logic [3:0]            flags_o
`endif
);

   localparam int QBITS = 26;

   generate
      if (DATA_WIDTH != 32) begin : g_width_check
         $error("fdiv_seq supports DATA_WIDTH=32 only");
      end
   endgenerate

   // ---------------------------------------------------------------- operands
   fp_class_e        a_cls, b_cls;
   logic             a_sign, b_sign;
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [MAN_W:0]   a_man, b_man;

   fp_classify u_cls_a (
      .op_i   (a_i[31:0]),
      .cls_o  (a_cls),
      .sign_o (a_sign),
      .exp_o  (a_exp),
      .man_o  (a_man)
   );

   fp_classify u_cls_b (
      .op_i   (b_i[31:0]),
      .cls_o  (b_cls),
      .sign_o (b_sign),
      .exp_o  (b_exp),
      .man_o  (b_man)
   );

   // --------------------------------------------------------------- registers
   fdiv_state_e       state_q, state_d;
   logic              sign_q, sign_d;
   logic signed [9:0] exp_q, exp_d;
   logic [MAN_W:0]    mb_q, mb_d;
   logic [MAN_W+1:0]  rem_q, rem_d;    // one bit wider: rem < 2*mb after shift
   logic [QBITS-1:0]  quo_q, quo_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [31:0]       c_q, c_d;
`ifdef FDIV_FLAGS_EN
   logic [3:0]        flags_q, flags_d;
   logic [3:0]        sp_flags;
`endif

   // ------------------------------------------------------ special operands
   logic        res_sign;
   logic        sp_hit;
   logic [31:0] sp_res;

   assign res_sign = a_sign ^ b_sign;

   always_comb begin
      sp_hit = 1'b1;
      sp_res = '0;
`ifdef FDIV_FLAGS_EN
      sp_flags = 4'b0000;
`endif
      if ((a_cls == FP_NAN) || (b_cls == FP_NAN) ||
          ((a_cls == FP_ZERO) && (b_cls == FP_ZERO)) ||
          ((a_cls == FP_INF) && (b_cls == FP_INF))) begin
         sp_res = QNAN;
`ifdef FDIV_FLAGS_EN
         sp_flags = 4'b1000;
`endif
      end else if (a_cls == FP_INF) begin
         sp_res = POS_INF | {res_sign, 31'b0};
      end else if (a_cls == FP_ZERO) begin
         sp_res = {res_sign, 31'b0};
      end else if (b_cls == FP_ZERO) begin
         sp_res = POS_INF | {res_sign, 31'b0};
`ifdef FDIV_FLAGS_EN
         sp_flags = 4'b0100;
`endif
      end else if (b_cls == FP_INF) begin
         sp_res = {res_sign, 31'b0};
      end else begin
         sp_hit = 1'b0;
      end
   end

   // ---------------------------------------------------- restoring step
   logic             rem_ge;
   logic [MAN_W+1:0] rem_sub;

   assign rem_ge  = (rem_q >= {1'b0, mb_q});
   assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

   // ---------------------------------------------------- normalise / round
   logic [QBITS-1:0]  q_n;
   logic signed [9:0] exp_n, exp_r;
   logic [MAN_W:0]    mant;
   logic              guard, sticky, round_up;
   logic [MAN_W+1:0]  mant_r;
   logic [MAN_W-1:0]  frac_r;
   logic              ovf, unf;
   logic [31:0]       norm_res;

   always_comb begin
      // Quotient lies in (0.5, 2); a clear top bit means one extra shift
      if (quo_q[QBITS-1]) begin
         q_n   = quo_q;
         exp_n = exp_q;
      end else begin
         q_n   = {quo_q[QBITS-2:0], 1'b0};
         exp_n = exp_q - 10'sd1;
      end
      mant     = q_n[QBITS-1:2];
      guard    = q_n[1];
      sticky   = q_n[0] | (|rem_q);
      round_up = guard & (sticky | mant[0]);
      mant_r   = {1'b0, mant} + {{MAN_W+1{1'b0}}, round_up};
      // Carry out of the rounding add: significand becomes 1.0, exponent +1
      if (mant_r[MAN_W+1]) begin
         exp_r  = exp_n + 10'sd1;
         frac_r = mant_r[MAN_W:1];
      end else begin
         exp_r  = exp_n;
         frac_r = mant_r[MAN_W-1:0];
      end
      ovf = (exp_r >= 10'sd255);
      unf = (exp_r <= 10'sd0);
      if (ovf) begin
         norm_res = POS_INF | {sign_q, 31'b0};
      end else if (unf) begin
         norm_res = {sign_q, 31'b0};
      end else begin
         norm_res = fp_pack(sign_q, exp_r[7:0], frac_r);
      end
   end

   // ------------------------------------------------- FSM next state / data
   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      mb_d    = mb_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
`ifdef FDIV_FLAGS_EN
      flags_d = flags_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               sign_d = res_sign;
               exp_d  = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;
               mb_d   = b_man;
               rem_d  = {1'b0, a_man};
               quo_d  = '0;
               cnt_d  = '0;
`ifdef FDIV_FLAGS_EN
               flags_d = 4'b0000;
`endif
               if (sp_hit) begin
                  c_d     = sp_res;
`ifdef FDIV_FLAGS_EN
                  flags_d = sp_flags;
`endif
                  state_d = S_DONE;
               end else begin
                  state_d = S_DIV;
               end
            end
         end
         S_DIV: begin
            quo_d = {quo_q[QBITS-2:0], rem_ge};
            rem_d = rem_sub << 1;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(QBITS - 1)) begin
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            c_d     = norm_res;
`ifdef FDIV_FLAGS_EN
            flags_d = {2'b00, ovf, unf};
`endif
            state_d = S_DONE;
         end
         S_DONE: begin
            if (res_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         mb_q    <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         c_q     <= '0;
`ifdef FDIV_FLAGS_EN
         flags_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         mb_q    <= mb_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
`ifdef FDIV_FLAGS_EN
         flags_q <= flags_d;
`endif
      end
   end

   // ----------------------------------------------------------------- outputs
   assign in_ready_o  = (state_q == S_IDLE);
   assign res_valid_o = (state_q == S_DONE);
   assign c_o         = c_q;
`ifdef FDIV_FLAGS_EN
   assign flags_o     = flags_q;
`endif

endmodule

// File: tb/tb_fdiv_seq.sv
// -----------------------------------------------------------------------------
// tb_fdiv_seq
// Directed self-checking bench for fdiv_seq. Expected results are queued when
// an operation is issued and popped when the divider presents its result.
// Latency is counted in clock edges starting with the accept edge.
// -----------------------------------------------------------------------------
module tb_fdiv_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] c;
`ifdef FDIV_FLAGS_EN
   logic [3:0]  flags;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] c;
      logic [3:0]  f;
      int          lat;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   fdiv_seq dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a),
      .b_i         (b),
      .res_valid_o (res_valid),
      .res_ready_i (res_ready),
      .c_o         (c)
`ifdef FDIV_FLAGS_EN
      ,
      .flags_o     (flags)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
      end
   endtask

   // Issue one operation, wait for the result, compare, optionally stall the
   // consumer for 'hold' cycles while offering a competing operand, then drain.
   task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] cv, input logic [3:0] fv,
                         input int lat, input int hold);
      exp_t        e;
      exp_t        got;
      int          n;
      logic [31:0] c_seen;
      e.c = cv; e.f = fv; e.lat = lat;
      sb_q.push_back(e);

      @(negedge clk);
      check({tag, ":in_ready"}, 32'(in_ready), 32'd1);
      a = av; b = bv; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; a = '0; b = '0;

      n = 1;
      while (n <= 100) begin
         @(negedge clk);
         if (res_valid) break;
         @(posedge clk);
         n++;
      end

      got = sb_q.pop_front();
      check({tag, ":latency"}, 32'(n), 32'(got.lat));
      check({tag, ":c"}, c, got.c);
`ifdef FDIV_FLAGS_EN
      check({tag, ":flags"}, 32'(flags), 32'(got.f));
`endif
      $display("op %s a=%08h b=%08h c=%08h expected=%08h latency=%0d", tag, av, bv, c, got.c, n);

      c_seen = c;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; a = 32'h3F80_0000; b = 32'h3F80_0000;
         @(posedge clk);
         @(negedge clk);
         check({tag, ":hold_valid"}, 32'(res_valid), 32'd1);
         check({tag, ":hold_c"}, c, c_seen);
         check({tag, ":hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0; a = '0; b = '0;

      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      @(negedge clk);
      check({tag, ":drain_valid"}, 32'(res_valid), 32'd0);
      check({tag, ":drain_in_ready"}, 32'(in_ready), 32'd1);
      if (hold > 0) begin
         // The operand offered during the stall must not have been taken
         repeat (3) @(negedge clk);
         check({tag, ":ignored_valid"}, 32'(res_valid), 32'd0);
         check({tag, ":ignored_in_ready"}, 32'(in_ready), 32'd1);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("reset:in_ready", 32'(in_ready), 32'd1);
      check("reset:res_valid", 32'(res_valid), 32'd0);
      check("reset:c", c, 32'h0000_0000);
`ifdef FDIV_FLAGS_EN
      check("reset:flags", 32'(flags), 32'd0);
`endif
      rst = 1'b0;

      run_op("6/2",       32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 28, 0);
      run_op("1/3",       32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 28, 0);
      run_op("-1/2",      32'hBF80_0000, 32'h4000_0000, 32'hBF00_0000, 4'b0000, 28, 0);
      run_op("10/5",      32'h4120_0000, 32'h40A0_0000, 32'h4000_0000, 4'b0000, 28, 0);
      run_op("1/0",       32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100,  1, 0);
      run_op("0/0",       32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000,  1, 0);
      run_op("nan/1",     32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000,  1, 0);
      run_op("inf/2",     32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 4'b0000,  1, 0);
      run_op("-2/inf",    32'hC000_0000, 32'h7F80_0000, 32'h8000_0000, 4'b0000,  1, 0);
      run_op("den/1",     32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0000,  1, 0);
      run_op("1/den",     32'h3F80_0000, 32'h0000_0001, 32'h7F80_0000, 4'b0100,  1, 0);
      run_op("overflow",  32'h7F7F_FFFF, 32'h3E80_0000, 32'h7F80_0000, 4'b0010, 28, 0);
      run_op("underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0001, 28, 0);
      run_op("stall",     32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 28, 5);

      // Reset in the middle of an iteration aborts the operation at once
      @(negedge clk);
      a = 32'h40C0_0000; b = 32'h4000_0000; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; a = '0; b = '0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("abort:busy", 32'(in_ready), 32'd0);
      rst = 1'b1;
      #1;
      check("abort:res_valid", 32'(res_valid), 32'd0);
      check("abort:in_ready", 32'(in_ready), 32'd1);
      $display("op abort reset asserted res_valid=%0b in_ready=%0b", res_valid, in_ready);
      @(negedge clk);
      rst = 1'b0;

      run_op("1.5/0.5",   32'h3FC0_0000, 32'h3F00_0000, 32'h4040_0000, 4'b0000, 28, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
